// File: rtl/program_loader.sv
// Boot loader: unpacks a length-prefixed, XOR-checksummed byte stream into RAM words
// starting at address 0, holding the core stalled until a good image has landed.
module program_loader_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= din;
  end
endmodule

module program_loader #(
  parameter int WORD_SIZE    = 64,
  parameter int ADDRESS_SIZE = 20,
  parameter int ADDR_STRIDE  = 4,
  parameter int MAX_WORDS    = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]    mem_data_in,
  output logic                    mem_write_en,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             words_loaded
);
  localparam int NB = WORD_SIZE / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [15:0]    MAXW   = 16'(MAX_WORDS);
  localparam logic [IW-1:0]  LASTB  = IW'(NB - 1);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  state_t state, stateNext;

  logic [15:0]          wordCount;
  logic [15:0]          lenFull;
  logic [15:0]          wordsNext;
  logic [IW-1:0]        byteIdx;
  logic [7:0]           xorAcc;
  logic                 xfer;
  logic                 arm;
  logic [NB-1:0]        laneLoad;
  logic [NB-1:0][7:0]   wordLanes;

  assign xfer      = in_valid && in_ready;
  assign lenFull   = {in_data, wordCount[7:0]};
  assign wordsNext = words_loaded + 16'd1;
  assign arm       = start && (state == IDLE || state == DONE || state == ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Handshake and status outputs depend on state only.
  always_comb begin
    stateNext    = state;
    in_ready     = 1'b0;
    mem_write_en = 1'b0;
    cpu_hold     = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      IDLE:   if (start) stateNext = LEN_LO;
      LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (lenFull > MAXW)      stateNext = ERROR;
          else if (lenFull == '0)  stateNext = CHECK;
          else                     stateNext = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && byteIdx == LASTB) stateNext = WRITE;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        stateNext    = (wordsNext == wordCount) ? CHECK : DATA;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = (in_data == xorAcc) ? DONE : ERROR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) stateNext = LEN_LO;
      end
      ERROR: begin
        error = 1'b1;
        if (start) stateNext = LEN_LO;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wordCount    <= '0;
      byteIdx      <= '0;
      xorAcc       <= '0;
      mem_address  <= '0;
      words_loaded <= '0;
    end else begin
      if (arm) begin
        words_loaded <= '0;
        mem_address  <= '0;
        xorAcc       <= '0;
      end
      if (state == LEN_LO && xfer) wordCount[7:0] <= in_data;
      if (state == LEN_HI && xfer) begin
        wordCount[15:8] <= in_data;
        byteIdx         <= '0;
      end
      if (state == DATA && xfer) begin
        xorAcc  <= xorAcc ^ in_data;
        byteIdx <= (byteIdx == LASTB) ? '0 : byteIdx + 1'b1;
      end
      if (state == WRITE) begin
        mem_address  <= mem_address + ADDRESS_SIZE'(ADDR_STRIDE);
        words_loaded <= wordsNext;
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : gLane
    assign laneLoad[g] = (state == DATA) && xfer && (byteIdx == IW'(g));
    program_loader_lane uLane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (laneLoad[g]),
      .din  (in_data),
      .q    (wordLanes[g])
    );
  end

  assign mem_data_in = wordLanes;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: drives byte streams with optional stalls and checks RAM writes
// and status against a queue-based image model.
module tb_program_loader;
  localparam int WS = 64;
  localparam int AS = 20;
  localparam int NB = WS / 8;

  logic          clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0]    in_data = 0;
  logic          in_ready, mem_write_en, cpu_hold, done, error;
  logic [AS-1:0] mem_address;
  logic [WS-1:0] mem_data_in;
  logic [15:0]   words_loaded;

  program_loader #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .ADDR_STRIDE(4), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, readyViol = 0;
  bit monReady = 0;
  logic [AS-1:0] wAddr[$];
  logic [WS-1:0] wData[$];
  int            wCyc[$];
  logic [WS-1:0] img[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_write_en === 1'b1) begin
      wAddr.push_back(mem_address);
      wData.push_back(mem_data_in);
      wCyc.push_back(cyc);
    end
    if (monReady && (in_ready === mem_write_en)) readyViol++;
  end

  function automatic logic [7:0] img_xor();
    logic [7:0] x = 0;
    logic [WS-1:0] w;
    foreach (img[i]) begin
      w = img[i];
      for (int j = 0; j < NB; j++) x ^= w[8*j +: 8];
    end
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit rdy = 0;
    int k;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(negedge clk); in_valid = 0; end
    @(negedge clk);
    in_valid = 1;
    in_data  = b;
    for (k = 0; k < 40; k++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
    end
    if (k == 40) begin
      total++; bad++;
      $display("FAIL send_byte_timeout: byte %02h not accepted in 40 cycles", b);
    end
    #1;
  endtask

  task automatic do_start();
    wAddr.delete(); wData.delete(); wCyc.delete();
    readyViol = 0;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start    = 0;
    monReady = 1;
  endtask

  task automatic run_load(input int n, input bit gaps, input logic [7:0] sum);
    logic [WS-1:0] w;
    do_start();
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int j = 0; j < NB; j++) send_byte(w[8*j +: 8], gaps);
    end
    send_byte(sum, gaps);
    monReady = 0;
    in_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    total++;
    if ({cpu_hold, in_ready, mem_write_en, done, error} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags: got %b want 10000", {cpu_hold, in_ready, mem_write_en, done, error});
    end
    total++;
    if (mem_address !== '0 || mem_data_in !== '0 || words_loaded !== '0) begin
      bad++; $display("FAIL reset_regs: addr=%h data=%h words=%0d want 0", mem_address, mem_data_in, words_loaded);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    total++;
    if (cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL idle_hold: cpu_hold=%b in_ready=%b want 1 0", cpu_hold, in_ready);
    end
  endtask

  task automatic test_known_image();
    img = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
    run_load(2, 0, 8'h00);
    total++;
    if (wAddr.size() != 2) begin
      bad++; $display("FAIL known_count: got %0d writes want 2", wAddr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (wAddr[i] !== AS'(4*i) || wData[i] !== img[i]) begin
          bad++; $display("FAIL known_write%0d: got %h@%h want %h@%h", i, wData[i], wAddr[i], img[i], 4*i);
        end
      end
    end
    total++;
    if ({done, error, cpu_hold} !== 3'b100 || words_loaded !== 16'd2) begin
      bad++; $display("FAIL known_status: dec=%b words=%0d want 100 2", {done, error, cpu_hold}, words_loaded);
    end
  endtask

  task automatic test_bad_checksum();
    img = '{64'hFFFF_FFFF_FFFF_FFFF};
    run_load(1, 0, 8'h01);
    total++;
    if (wAddr.size() != 1 || wData[0] !== img[0]) begin
      bad++; $display("FAIL badsum_write: got %0d writes want 1 of %h", wAddr.size(), img[0]);
    end
    total++;
    if ({done, error, cpu_hold} !== 3'b011) begin
      bad++; $display("FAIL badsum_status: dec=%b want 011", {done, error, cpu_hold});
    end
  endtask

  task automatic test_empty_image();
    img.delete();
    run_load(0, 0, 8'h00);
    total++;
    if (wAddr.size() != 0 || done !== 1'b1 || words_loaded !== 16'd0) begin
      bad++; $display("FAIL empty: writes=%0d done=%b words=%0d want 0 1 0", wAddr.size(), done, words_loaded);
    end
  endtask

  task automatic test_too_long();
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    monReady = 0;
    @(negedge clk);
    total++;
    if (error !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      bad++; $display("FAIL too_long_status: err=%b rdy=%b done=%b hold=%b want 1 0 0 1", error, in_ready, done, cpu_hold);
    end
    repeat (3) @(negedge clk);
    in_valid = 0;
    total++;
    if (wAddr.size() != 0 || error !== 1'b1) begin
      bad++; $display("FAIL too_long_nowrite: writes=%0d err=%b want 0 1", wAddr.size(), error);
    end
  endtask

  task automatic test_random_gaps();
    img.delete();
    repeat (3) img.push_back({$urandom, $urandom});
    run_load(3, 1, img_xor());
    total++;
    if (wAddr.size() != 3) begin
      bad++; $display("FAIL gaps_count: got %0d writes want 3", wAddr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wAddr[i] !== AS'(4*i) || wData[i] !== img[i]) begin
          bad++; $display("FAIL gaps_write%0d: got %h@%h want %h@%h", i, wData[i], wAddr[i], img[i], 4*i);
        end
      end
    end
    total++;
    if (readyViol != 0 || done !== 1'b1) begin
      bad++; $display("FAIL gaps_ready: viol=%0d done=%b want 0 1", readyViol, done);
    end
  endtask

  task automatic test_back_to_back();
    img.delete();
    repeat (4) img.push_back({$urandom, $urandom});
    run_load(4, 0, img_xor());
    total++;
    if (wAddr.size() != 4) begin
      bad++; $display("FAIL b2b_count: got %0d writes want 4", wAddr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wAddr[i] !== AS'(4*i) || wData[i] !== img[i]) begin
          bad++; $display("FAIL b2b_write%0d: got %h@%h want %h@%h", i, wData[i], wAddr[i], img[i], 4*i);
        end
        if (i > 0) begin
          total++;
          if (wCyc[i] - wCyc[i-1] != NB + 1) begin
            bad++; $display("FAIL b2b_rate%0d: got %0d cycles want %0d", i, wCyc[i] - wCyc[i-1], NB + 1);
          end
        end
      end
    end
    total++;
    if (done !== 1'b1 || readyViol != 0 || words_loaded !== 16'd4) begin
      bad++; $display("FAIL b2b_status: done=%b viol=%0d words=%0d want 1 0 4", done, readyViol, words_loaded);
    end
  endtask

  task automatic test_reset_midload();
    logic [WS-1:0] w;
    img.delete();
    img.push_back({$urandom, $urandom});
    img.push_back({$urandom, $urandom});
    w = img[0];
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 0);
    @(negedge clk);
    in_valid = 1;
    in_data  = w[39:32];
    #1;
    monReady = 0;
    rst_n    = 0;
    #1;
    total++;
    if ({cpu_hold, in_ready, mem_write_en, done, error} !== 5'b10000 ||
        mem_address !== '0 || mem_data_in !== '0 || words_loaded !== '0) begin
      bad++; $display("FAIL midreset: flags=%b addr=%h data=%h words=%0d want 10000 0 0 0",
                      {cpu_hold, in_ready, mem_write_en, done, error}, mem_address, mem_data_in, words_loaded);
    end
    @(negedge clk);
    in_valid = 0;
    rst_n    = 1;
    total++;
    if (wAddr.size() != 0) begin
      bad++; $display("FAIL midreset_nowrite: got %0d writes want 0", wAddr.size());
    end
    img.delete();
    img.push_back({$urandom, $urandom});
    run_load(1, 0, img_xor());
    total++;
    if (wAddr.size() != 1 || wAddr[0] !== '0 || wData[0] !== img[0] || done !== 1'b1) begin
      bad++; $display("FAIL reload: writes=%0d data=%h done=%b want 1 %h 1", wAddr.size(),
                      (wData.size() > 0) ? wData[0] : '0, done, img[0]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_known_image();
    test_bad_checksum();
    test_empty_image();
    test_too_long();
    test_random_gaps();
    test_back_to_back();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
